// File: rtl/brom_copy_master.sv
`default_nettype none
// ============================================================================
// Module      : brom_copy_master
// Description : Bus initiator that shadow-copies a block of words from the
//               boot ROM to RAM, with optional read-back verification.
// Revision    : 1.0 - initial release
// ============================================================================
module brom_copy_master #(
    parameter logic [31:0] SRC_ADDR   = 32'h2000_0000,
    parameter logic [31:0] DST_ADDR   = 32'h0000_0000,
    parameter int          COPY_WORDS = 1024,
    parameter int          TIMEOUT    = 255,
    parameter bit          VERIFY     = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [15:0] words_done,
    output logic        mem_valid,
    output logic        mem_instr,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [15:0] c_COPY_WORDS   = 16'(COPY_WORDS);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam bit          c_MISALIGNED   = (SRC_ADDR[1:0] != 2'b00) || (DST_ADDR[1:0] != 2'b00);

    localparam logic [1:0] c_ERR_NONE     = 2'b00;
    localparam logic [1:0] c_ERR_TIMEOUT  = 2'b01;
    localparam logic [1:0] c_ERR_VERIFY   = 2'b10;
    localparam logic [1:0] c_ERR_ALIGN    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD_SRC = 3'd1,
        S_WR_DST = 3'd2,
        S_RD_VER = 3'd3,
        S_GAP    = 3'd4,
        S_FIN    = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t      r_state;
    state_t      r_after_gap;
    logic [31:0] r_data;
    logic [15:0] r_words;
    logic [15:0] r_wait;
    logic [1:0]  r_err_code;

    state_t      w_next;
    state_t      w_after_gap;
    logic [1:0]  w_err_code;
    logic        w_in_txn;
    logic        w_hs;
    logic        w_timeout;
    logic        w_last;
    logic        w_start_ok;
    logic        w_word_done;
    logic [31:0] w_offset;

    assign w_in_txn  = (r_state == S_RD_SRC) || (r_state == S_WR_DST) || (r_state == S_RD_VER);
    assign w_hs      = w_in_txn && mem_ready;
    // The wait that would bring the count to TIMEOUT aborts; a ready in that cycle completes instead.
    assign w_timeout = w_in_txn && !mem_ready && (r_wait == c_TIMEOUT_LAST);
    assign w_last    = (r_words + 16'd1) == c_COPY_WORDS;
    assign w_offset  = {14'd0, r_words, 2'b00};

    always_comb begin
        w_next      = r_state;
        w_after_gap = r_after_gap;
        w_err_code  = r_err_code;
        w_start_ok  = 1'b0;
        w_word_done = 1'b0;
        case (r_state)
            S_IDLE, S_FIN, S_ERR: begin
                if (start) begin
                    w_start_ok = 1'b1;
                    w_err_code = c_ERR_NONE;
                    if (c_MISALIGNED) begin
                        w_next     = S_ERR;
                        w_err_code = c_ERR_ALIGN;
                    end else if (c_COPY_WORDS == 16'd0) begin
                        w_next = S_FIN;
                    end else begin
                        w_next = S_RD_SRC;
                    end
                end
            end
            S_RD_SRC: begin
                if (w_hs) begin
                    w_next      = S_GAP;
                    w_after_gap = S_WR_DST;
                end else if (w_timeout) begin
                    w_next     = S_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            S_WR_DST: begin
                if (w_hs) begin
                    if (VERIFY) begin
                        w_next      = S_GAP;
                        w_after_gap = S_RD_VER;
                    end else begin
                        w_word_done = 1'b1;
                        w_next      = w_last ? S_FIN : S_GAP;
                        w_after_gap = S_RD_SRC;
                    end
                end else if (w_timeout) begin
                    w_next     = S_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            S_RD_VER: begin
                if (w_hs) begin
                    if (mem_rdata != r_data) begin
                        w_next     = S_ERR;
                        w_err_code = c_ERR_VERIFY;
                    end else begin
                        w_word_done = 1'b1;
                        w_next      = w_last ? S_FIN : S_GAP;
                        w_after_gap = S_RD_SRC;
                    end
                end else if (w_timeout) begin
                    w_next     = S_ERR;
                    w_err_code = c_ERR_TIMEOUT;
                end
            end
            S_GAP: begin
                w_next = r_after_gap;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_after_gap <= S_RD_SRC;
            r_data      <= 32'd0;
            r_words     <= 16'd0;
            r_wait      <= 16'd0;
            r_err_code  <= c_ERR_NONE;
        end else begin
            r_state     <= w_next;
            r_after_gap <= w_after_gap;
            r_err_code  <= w_err_code;
            if (w_start_ok) begin
                r_words <= 16'd0;
            end else if (w_word_done) begin
                r_words <= r_words + 16'd1;
            end
            if ((r_state == S_RD_SRC) && mem_ready) begin
                r_data <= mem_rdata;
            end
            if (!w_in_txn) begin
                r_wait <= 16'd0;
            end else if (!mem_ready) begin
                r_wait <= r_wait + 16'd1;
            end
        end
    end

    always_comb begin
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_wstrb = 4'b0000;
        case (r_state)
            S_RD_SRC: mem_addr = SRC_ADDR + w_offset;
            S_WR_DST: begin
                mem_addr  = DST_ADDR + w_offset;
                mem_wdata = r_data;
                mem_wstrb = 4'b1111;
            end
            S_RD_VER: mem_addr = DST_ADDR + w_offset;
            default:  mem_addr = 32'd0;
        endcase
    end

    assign mem_valid  = w_in_txn;
    assign mem_instr  = 1'b0;
    assign busy       = w_in_txn || (r_state == S_GAP);
    assign done       = (r_state == S_FIN);
    assign error      = (r_state == S_ERR);
    assign err_code   = r_err_code;
    assign words_done = r_words;

endmodule
`default_nettype wire

// File: doc/brom_copy_master.md
Name: brom_copy_master

Overview:
- Bus initiator on the same native memory interface the boot ROM and its CSRs serve: mem_valid/mem_ready/mem_addr/mem_wdata/mem_wstrb/mem_rdata.
- On a start pulse it copies a fixed block of 32-bit words from the boot ROM region to RAM.
- With VERIFY set, it reads each destination word back and compares it to the source word.
- It sits beside the CPU behind the bus arbiter and performs the boot-image shadow copy before the core is released.

Parameters:
- SRC_ADDR, 32'h2000_0000, source base byte address; bits [1:0] must be 0.
- DST_ADDR, 32'h0000_0000, destination base byte address; bits [1:0] must be 0.
- COPY_WORDS, 1024, number of 32-bit words to copy; range 0..65535.
- TIMEOUT, 255, maximum cycles to wait for mem_ready on one transaction; range 1..65535.
- VERIFY, 1'b1, 1 enables a read-back compare after every write.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a copy; ignored unless in IDLE, DONE or ERR.
- busy  out  1  high while a copy is in progress.
- done  out  1  sticky; set when all words are copied; cleared by start or reset.
- error  out  1  sticky; set on abort; cleared by start or reset.
- err_code  out  2  00 none, 01 timeout, 10 verify mismatch, 11 misaligned base parameter.
- words_done  out  16  number of words fully completed (written, and verified if VERIFY).
- mem_valid  out  1  transaction request.
- mem_instr  out  1  tied 0.
- mem_ready  in  1  responder completion.
- mem_addr  out  32  byte address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'b0000 for reads, 4'b1111 for writes.
- mem_rdata  in  32  read data, valid in the cycle mem_ready is high.

Behaviour:
- Reset values:
  - mem_valid, mem_wstrb, mem_addr, mem_wdata, busy, done, error, err_code and words_done are all 0.
  - The state machine is in IDLE.
  - Reset mid-transfer aborts at the next edge; no further bus activity occurs.
- States: IDLE, RD_SRC, WR_DST, RD_VER, GAP, FIN, ERR.
- start accepted in IDLE, FIN or ERR:
  - clears done, error, err_code and words_done; index i = 0.
  - If SRC_ADDR[1:0] or DST_ADDR[1:0] is nonzero: go to ERR with err_code=11 and no bus traffic.
  - Else if COPY_WORDS == 0: go to FIN (done=1 in the next cycle).
  - Else: go to RD_SRC, with mem_valid=1 in the next cycle.
- start while busy is ignored.
- RD_SRC:
  - Drives mem_addr = SRC_ADDR + 4*i (32-bit wrap) and mem_wstrb = 0.
  - On mem_ready: latch mem_rdata into data_q.
- WR_DST:
  - Drives mem_addr = DST_ADDR + 4*i, mem_wdata = data_q, mem_wstrb = 4'b1111.
- RD_VER (VERIFY=1 only):
  - Drives mem_addr = DST_ADDR + 4*i and mem_wstrb = 0.
  - On mem_ready: if mem_rdata != data_q, go to ERR with err_code=10.
- Handshake rules:
  - mem_valid rises on entry to a transaction state.
  - mem_addr, mem_wdata and mem_wstrb stay constant while mem_valid is high.
  - In the cycle mem_ready is sampled high, mem_valid drops at the next edge, and the FSM spends exactly one cycle in GAP with mem_valid=0 before the next transaction.
  - This gap is required because the responder derives ready from the previous cycle's valid.
- Transaction order per word: RD_SRC → GAP → WR_DST → GAP → (RD_VER → GAP).
- Word completion:
  - After the last transaction of a word completes, words_done increments and i increments.
  - If i+1 == COPY_WORDS: go to FIN. Otherwise go to the next RD_SRC.
- Timeout:
  - A 16-bit wait counter clears at each transaction start and counts cycles with mem_valid=1 and mem_ready=0.
  - When the count reaches TIMEOUT: mem_valid=0 at the next edge, then ERR with err_code=01.
  - A mem_ready arriving in the same cycle the count reaches TIMEOUT wins; this is not a timeout.
- FIN: done=1, busy=0. ERR: error=1, busy=0.
- words_done holds its value after FIN or ERR.
- mem_ready while mem_valid=0 is ignored.
- Minimum latency per word against a 1-cycle responder: 6 cycles without verify, 9 with VERIFY=1.

Test Plan:
- COPY_WORDS=4, VERIFY=1, source = 0x11111111..0x44444444, 1-cycle responder, pulse start:
  - RAM 0x0..0xC holds the same data.
  - done=1, error=0, words_done=4.
  - mem_valid is low for exactly 1 cycle between transactions.
- Responder with 3-cycle ready latency, COPY_WORDS=2:
  - addr, wdata and wstrb are stable while valid is high.
  - Completes with words_done=2.
- Responder never asserts ready on word 1 write, TIMEOUT=8:
  - mem_valid drops after 8 wait cycles.
  - error=1, err_code=01, words_done=1.
- RAM model corrupts the readback of word 2 (bit 0 flipped):
  - err_code=10, words_done=2, no write to word 3.
- Parameter and start edge cases:
  - DST_ADDR=32'h2 → err_code=11 and mem_valid never asserts.
  - COPY_WORDS=0 → done=1 one cycle after start.
- Mid-copy corner cases:
  - start pulsed mid-copy → ignored.
  - reset asserted mid-copy → all outputs 0 next cycle; a fresh start then completes normally.
